round_sequencer: RTL and testbench

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/round_sequencer.sv | 131 +++++++++++++
 tb/tb_round_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Round/lives/level sequencer for a frogger-style game: one-second prescaler,
// IDLE/PLAY/DIE/LVLUP/WIN/OVER FSM. Define ROUND_TIMEOUT_EN to enable the per-life timeout.
module round_sequencer #(
  parameter int CLK_DIV     = 100000000,
  parameter int ROUND_SECS  = 30,
  parameter int PAUSE_SECS  = 2,
  parameter int GOAL_Y      = 90,
  parameter int NUM_LEVELS  = 5,
  parameter int START_LIVES = 4
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       start_i,
  input  logic       collision_i,
  input  logic [8:0] frog_y,
  output logic       respawn_o,
  output logic       freeze_o,
  output logic [2:0] level_o,
  output logic [2:0] lives_o,
  output logic [5:0] time_left_o,
  output logic [2:0] state_o,
  output logic       gameover_o,
  output logic       gamewin_o
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_DIE   = 3'd2;
  localparam logic [2:0] S_LVLUP = 3'd3;
  localparam logic [2:0] S_WIN   = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int PW = $clog2(PAUSE_SECS + 1);

  logic [CW-1:0] div_cnt;
  logic [PW-1:0] pause_cnt;
  logic [2:0]    state, nxt_state, nxt_level, nxt_lives;
  logic [5:0]    nxt_time;
  logic          start_q, start_rise, goal, tick, lose;

  assign tick       = (div_cnt == CW'(CLK_DIV - 1));
  assign start_rise = start_i & ~start_q;
  assign goal       = (frog_y <= 9'(GOAL_Y));
  assign state_o    = state;

  always_comb begin
    nxt_state = state;
    nxt_level = level_o;
    nxt_lives = lives_o;
    nxt_time  = time_left_o;
    lose      = 1'b0;
    case (state)
      S_IDLE:
        if (start_rise) begin
          nxt_state = S_PLAY;
          nxt_level = 3'd0;
          nxt_lives = 3'(START_LIVES);
          nxt_time  = 6'(ROUND_SECS);
        end
      S_PLAY:
        // goal outranks collision, which outranks timeout
        if (goal) begin
          if (level_o < 3'(NUM_LEVELS - 1)) begin
            nxt_state = S_LVLUP;
            nxt_level = level_o + 3'd1;
            nxt_lives = 3'(START_LIVES);
          end else begin
            nxt_state = S_WIN;
          end
        end else if (collision_i) begin
          lose = 1'b1;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (tick) begin
          if (time_left_o <= 6'd1) begin
            nxt_time = 6'd0;
            lose     = 1'b1;
          end else begin
            nxt_time = time_left_o - 6'd1;
          end
        end
`endif
      S_DIE, S_LVLUP:
        if (tick && pause_cnt == PW'(PAUSE_SECS - 1)) begin
          nxt_state = S_PLAY;
          nxt_time  = 6'(ROUND_SECS);
        end
      S_WIN, S_OVER:
        if (start_rise) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
    if (lose) begin
      nxt_lives = (lives_o == 3'd0) ? 3'd0 : lives_o - 3'd1;
      nxt_state = (lives_o <= 3'd1) ? S_OVER : S_DIE;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state       <= S_IDLE;
      level_o     <= 3'd0;
      lives_o     <= 3'(START_LIVES);
      time_left_o <= 6'(ROUND_SECS);
      respawn_o   <= 1'b0;
      freeze_o    <= 1'b1;
      gameover_o  <= 1'b0;
      gamewin_o   <= 1'b0;
      div_cnt     <= '0;
      pause_cnt   <= '0;
      start_q     <= 1'b0;
    end else begin
      state       <= nxt_state;
      level_o     <= nxt_level;
      lives_o     <= nxt_lives;
      time_left_o <= nxt_time;
      respawn_o   <= (nxt_state == S_PLAY) && (state != S_PLAY);
      freeze_o    <= (nxt_state != S_PLAY);
      gameover_o  <= (nxt_state == S_OVER);
      gamewin_o   <= (nxt_state == S_WIN);
      start_q     <= start_i;
      // every state entry restarts the second and pause timing
      if (nxt_state != state) begin
        div_cnt   <= '0;
        pause_cnt <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + CW'(1);
        if (tick) pause_cnt <= pause_cnt + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: stimulus queues expected snapshots
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_round_sequencer;
  logic       clk_in = 1'b0;
  logic       reset_in, start_i, collision_i;
  logic [8:0] frog_y;
  logic       respawn_o, freeze_o, gameover_o, gamewin_o;
  logic [2:0] level_o, lives_o, state_o;
  logic [5:0] time_left_o;

  round_sequencer #(
    .CLK_DIV(4), .ROUND_SECS(3), .PAUSE_SECS(2), .GOAL_Y(90),
    .NUM_LEVELS(5), .START_LIVES(4)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .start_i(start_i),
    .collision_i(collision_i), .frog_y(frog_y), .respawn_o(respawn_o),
    .freeze_o(freeze_o), .level_o(level_o), .lives_o(lives_o),
    .time_left_o(time_left_o), .state_o(state_o),
    .gameover_o(gameover_o), .gamewin_o(gamewin_o)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] lvl;
    logic [2:0] lives;
    logic [5:0] tl;
    logic       frz;
    logic       rsp;
    logic       ov;
    logic       wn;
  } obs_t;

  int    cq[$];
  obs_t  vq[$];
  string nq[$];
  int    checks = 0;
  int    failures = 0;
  int    lv;

  task automatic ex(input int k, input string nm, input logic [2:0] st,
                    input logic [2:0] lvl, input logic [2:0] lives,
                    input logic [5:0] tl, input logic rsp);
    obs_t o;
    o.st = st; o.lvl = lvl; o.lives = lives; o.tl = tl; o.rsp = rsp;
    o.frz = (st != 3'd1);
    o.ov  = (st == 3'd5);
    o.wn  = (st == 3'd4);
    cq.push_back(cyc + k);
    vq.push_back(o);
    nq.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  always @(negedge clk_in) begin
    obs_t  a, e;
    int    c;
    string nm;
    a = {state_o, level_o, lives_o, time_left_o, freeze_o, respawn_o, gameover_o, gamewin_o};
    while (cq.size() > 0 && cq[0] <= cyc) begin
      c  = cq.pop_front();
      e  = vq.pop_front();
      nm = nq.pop_front();
      checks++;
      if (c != cyc || a !== e) begin
        failures++;
        $display("FAIL %s cyc=%0d due=%0d got st=%0d lvl=%0d lives=%0d tl=%0d frz=%0b rsp=%0b ov=%0b wn=%0b exp st=%0d lvl=%0d lives=%0d tl=%0d frz=%0b rsp=%0b ov=%0b wn=%0b",
                 nm, cyc, c, a.st, a.lvl, a.lives, a.tl, a.frz, a.rsp, a.ov, a.wn,
                 e.st, e.lvl, e.lives, e.tl, e.frz, e.rsp, e.ov, e.wn);
      end
    end
  end

  initial begin
    reset_in = 1'b1; start_i = 1'b0; collision_i = 1'b0; frog_y = 9'd200;
    step(1);
    ex(1, "reset", 3'd0, 3'd0, 3'd4, 6'd3, 1'b0); step(2);
    reset_in = 1'b0;
    ex(1, "idle_after_reset", 3'd0, 3'd0, 3'd4, 6'd3, 1'b0); step(1);

    // start, then a collision, held high into DIE where it must be ignored
    start_i = 1'b1;
    ex(1, "start_play", 3'd1, 3'd0, 3'd4, 6'd3, 1'b1);
    ex(2, "respawn_one_cycle", 3'd1, 3'd0, 3'd4, 6'd3, 1'b0);
    step(1); start_i = 1'b0; step(1);
    collision_i = 1'b1;
    ex(1, "collide_die", 3'd2, 3'd0, 3'd3, 6'd3, 1'b0); step(1);
    ex(3, "collision_ignored_in_die", 3'd2, 3'd0, 3'd3, 6'd3, 1'b0); step(3);
    collision_i = 1'b0;
    ex(4, "die_hold", 3'd2, 3'd0, 3'd3, 6'd3, 1'b0);
    ex(5, "die_respawn", 3'd1, 3'd0, 3'd3, 6'd3, 1'b1); step(5);

    // goal and collision in the same cycle; start edge during LVLUP ignored
    frog_y = 9'd90; collision_i = 1'b1;
    ex(1, "goal_beats_collision", 3'd3, 3'd1, 3'd4, 6'd3, 1'b0); step(1);
    frog_y = 9'd200; collision_i = 1'b0; start_i = 1'b1;
    ex(2, "start_ignored_lvlup", 3'd3, 3'd1, 3'd4, 6'd3, 1'b0); step(2);
    start_i = 1'b0;
    ex(6, "lvlup_respawn", 3'd1, 3'd1, 3'd4, 6'd3, 1'b1); step(6);

    // idle in PLAY
`ifdef ROUND_TIMEOUT_EN
    ex(4,  "tick_dec",        3'd1, 3'd1, 3'd4, 6'd2, 1'b0);
    ex(11, "tl_one",          3'd1, 3'd1, 3'd4, 6'd1, 1'b0);
    ex(12, "timeout_loss",    3'd2, 3'd1, 3'd3, 6'd0, 1'b0);
    ex(20, "timeout_respawn", 3'd1, 3'd1, 3'd3, 6'd3, 1'b1);
    lv = 3;
`else
    ex(4,  "no_tick_dec", 3'd1, 3'd1, 3'd4, 6'd3, 1'b0);
    ex(12, "no_timeout",  3'd1, 3'd1, 3'd4, 6'd3, 1'b0);
    ex(20, "still_play",  3'd1, 3'd1, 3'd4, 6'd3, 1'b0);
    lv = 4;
`endif
    step(20);

    // lose remaining lives down to OVER
    while (lv > 1) begin
      collision_i = 1'b1;
      ex(1, "loss_die", 3'd2, 3'd1, 3'(lv - 1), 6'd3, 1'b0); step(1);
      collision_i = 1'b0;
      lv--;
      ex(8, "loss_respawn", 3'd1, 3'd1, 3'(lv), 6'd3, 1'b1); step(8);
    end
    collision_i = 1'b1;
    ex(1, "over", 3'd5, 3'd1, 3'd0, 6'd3, 1'b0); step(1);
    ex(3, "over_ignores_collision", 3'd5, 3'd1, 3'd0, 6'd3, 1'b0); step(3);
    collision_i = 1'b0;
    start_i = 1'b1;
    ex(1, "over_to_idle", 3'd0, 3'd1, 3'd0, 6'd3, 1'b0); step(1);
    start_i = 1'b0; step(1);

    // climb all levels to WIN
    start_i = 1'b1;
    ex(1, "restart", 3'd1, 3'd0, 3'd4, 6'd3, 1'b1); step(1);
    start_i = 1'b0; frog_y = 9'd91;
    ex(2, "y91_no_goal", 3'd1, 3'd0, 3'd4, 6'd3, 1'b0); step(2);
    for (int l = 0; l < 4; l++) begin
      frog_y = 9'd50;
      ex(1, "goal_lvlup", 3'd3, 3'(l + 1), 3'd4, 6'd3, 1'b0); step(1);
      frog_y = 9'd200;
      ex(8, "lvl_play", 3'd1, 3'(l + 1), 3'd4, 6'd3, 1'b1); step(8);
    end
    frog_y = 9'd90;
    ex(1, "win", 3'd4, 3'd4, 3'd4, 6'd3, 1'b0); step(1);
    frog_y = 9'd200;
    ex(1, "win_hold", 3'd4, 3'd4, 3'd4, 6'd3, 1'b0); step(2);
    reset_in = 1'b1;
    ex(0, "async_reset", 3'd0, 3'd0, 3'd4, 6'd3, 1'b0); step(1);
    reset_in = 1'b0;
    ex(1, "idle_after_win_reset", 3'd0, 3'd0, 3'd4, 6'd3, 1'b0); step(1);

    for (int i = 0; i < 60 && cq.size() > 0; i++) @(posedge clk_in);
    if (cq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", cq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
